// File: rtl/lcd_timing_pattern_gen.sv
// Parametrised LCD timing generator with registered HSYNC/VSYNC/DE and a
// frame-latched, horizontally scrollable test-pattern source.
module lcd_timing_pattern_gen #(
   parameter int H_SYNC   = 1,
   parameter int H_BP     = 182,
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 210,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 0,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 45,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int CNT_W    = 12,
   parameter int CHK_LOG2 = 5
) (
   input  logic             PixelClk,
   input  logic             RST,
   input  logic [1:0]       Mode,
   input  logic             ScrollEn,
   input  logic [15:0]      SolidRGB,
   output logic             LCD_DE,
   output logic             LCD_HSYNC,
   output logic             LCD_VSYNC,
   output logic [4:0]       LCD_R,
   output logic [5:0]       LCD_G,
   output logic [4:0]       LCD_B,
   output logic [CNT_W-1:0] PixelX,
   output logic [CNT_W-1:0] PixelY,
   output logic             FrameStart
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_SYNC + H_BP);
   localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_SYNC + V_BP);
   localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(H_ACTIVE - 1);
   localparam logic             HS_ACT    = 1'(HS_POL);
   localparam logic             VS_ACT    = 1'(VS_POL);

   typedef enum logic [1:0] {
      MODE_BARS  = 2'd0,
      MODE_GRAD  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_SOLID = 2'd3
   } mode_e;

   logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, off_q, off_d;
   mode_e            mode_q, mode_d;
   logic             scroll_en_q, scroll_en_d;
   logic [15:0]      solid_q, solid_d;

   logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
   logic [15:0]      rgb_q, rgb_d;
   logic [CNT_W-1:0] px_q, px_d, py_q, py_d;

   logic             h_wrap, frame_start, hsync, vsync, h_act, v_act;
   logic [CNT_W-1:0] x, y, xs, off_room;
   logic [2:0]       bar_idx;
   logic [2:0]       bar_rgb;
   logic [15:0]      pix;

   // Raster counters plus the per-frame snapshot of the pattern controls;
   // scroll advances using the enable captured for the frame now ending.
   always_comb begin
      h_wrap      = (hcnt_q == H_LAST);
      frame_start = (hcnt_q == '0) && (vcnt_q == '0);
      hcnt_d      = h_wrap ? '0 : hcnt_q + 1'b1;
      vcnt_d      = vcnt_q;
      if (h_wrap) begin
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end
      mode_d      = mode_q;
      scroll_en_d = scroll_en_q;
      solid_d     = solid_q;
      off_d       = off_q;
      if (frame_start) begin
         mode_d      = mode_e'(Mode);
         scroll_en_d = ScrollEn;
         solid_d     = SolidRGB;
         if (scroll_en_q) begin
            off_d = (off_q == OFF_LAST) ? '0 : off_q + 1'b1;
         end
      end
   end

   // Timing decode and pattern generation for the current counter position.
   always_comb begin
      hsync    = (hcnt_q < H_SYNC_C);
      vsync    = (vcnt_q < V_SYNC_C);
      h_act    = (hcnt_q >= H_START_C) && (hcnt_q < H_END_C);
      v_act    = (vcnt_q >= V_START_C) && (vcnt_q < V_END_C);
      x        = hcnt_q - H_START_C;
      y        = vcnt_q - V_START_C;
      // Both x and off are below H_ACTIVE, so one conditional subtract wraps.
      off_room = H_ACT_C - off_q;
      xs       = (x >= off_room) ? (x - off_room) : (x + off_q);

      bar_idx = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (xs >= CNT_W'(i * BAR_W)) begin
            bar_idx = 3'(i);
         end
      end
      case (bar_idx)
         3'd0:    bar_rgb = 3'b111;
         3'd1:    bar_rgb = 3'b110;
         3'd2:    bar_rgb = 3'b011;
         3'd3:    bar_rgb = 3'b010;
         3'd4:    bar_rgb = 3'b101;
         3'd5:    bar_rgb = 3'b100;
         3'd6:    bar_rgb = 3'b001;
         default: bar_rgb = 3'b000;
      endcase

      pix = '0;
      case (mode_q)
         MODE_BARS:  pix = {{5{bar_rgb[2]}}, {6{bar_rgb[1]}}, {5{bar_rgb[0]}}};
         MODE_GRAD:  pix = {xs[7:3], y[7:2], 5'((xs[7:0] + y[7:0]) >> 3)};
         MODE_CHECK: pix = (xs[CHK_LOG2] ^ y[CHK_LOG2]) ? 16'hFFFF : 16'h0000;
         MODE_SOLID: pix = solid_q;
         default:    pix = '0;
      endcase

      de_d  = h_act & v_act;
      hs_d  = ~(hsync ^ HS_ACT);
      vs_d  = ~(vsync ^ VS_ACT);
      fs_d  = frame_start;
      rgb_d = de_d ? pix : '0;
      px_d  = de_d ? x : '0;
      py_d  = de_d ? y : '0;
   end

   always_ff @(posedge PixelClk) begin
      if (RST) begin
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         off_q       <= '0;
         mode_q      <= MODE_BARS;
         scroll_en_q <= 1'b0;
         solid_q     <= '0;
         de_q        <= 1'b0;
         hs_q        <= ~HS_ACT;
         vs_q        <= ~VS_ACT;
         fs_q        <= 1'b0;
         rgb_q       <= '0;
         px_q        <= '0;
         py_q        <= '0;
      end else begin
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         off_q       <= off_d;
         mode_q      <= mode_d;
         scroll_en_q <= scroll_en_d;
         solid_q     <= solid_d;
         de_q        <= de_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         fs_q        <= fs_d;
         rgb_q       <= rgb_d;
         px_q        <= px_d;
         py_q        <= py_d;
      end
   end

   assign LCD_DE     = de_q;
   assign LCD_HSYNC  = hs_q;
   assign LCD_VSYNC  = vs_q;
   assign LCD_R      = rgb_q[15:11];
   assign LCD_G      = rgb_q[10:5];
   assign LCD_B      = rgb_q[4:0];
   assign PixelX     = px_q;
   assign PixelY     = py_q;
   assign FrameStart = fs_q;

endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Randomised self-checking bench: two polarity builds of the generator are
// compared every cycle against a frame-position reference model.
module tb_lcd_timing_pattern_gen;

   localparam int HS = 1, HBP = 2, HA = 8, HFP = 2;
   localparam int VS = 1, VBP = 1, VA = 4, VFP = 1;
   localparam int HT = HS + HBP + HA + HFP;
   localparam int VT = VS + VBP + VA + VFP;
   localparam int FT = HT * VT;
   localparam int CW = 12;
   localparam int CHK = 1;

   logic          PixelClk = 1'b0;
   logic          RST      = 1'b1;
   logic [1:0]    Mode     = 2'd0;
   logic          ScrollEn = 1'b0;
   logic [15:0]   SolidRGB = 16'h0000;

   logic          n_de, n_hs, n_vs, n_fs, p_de, p_hs, p_vs, p_fs;
   logic [4:0]    n_r, n_b, p_r, p_b;
   logic [5:0]    n_g, p_g;
   logic [CW-1:0] n_px, n_py, p_px, p_py;
   logic [15:0]   n_rgb;

   assign n_rgb = {n_r, n_g, n_b};

   lcd_timing_pattern_gen #(
      .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
      .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
      .HS_POL(0), .VS_POL(0), .CNT_W(CW), .CHK_LOG2(CHK)
   ) dut_n (
      .PixelClk(PixelClk), .RST(RST), .Mode(Mode), .ScrollEn(ScrollEn),
      .SolidRGB(SolidRGB), .LCD_DE(n_de), .LCD_HSYNC(n_hs), .LCD_VSYNC(n_vs),
      .LCD_R(n_r), .LCD_G(n_g), .LCD_B(n_b), .PixelX(n_px), .PixelY(n_py),
      .FrameStart(n_fs)
   );

   lcd_timing_pattern_gen #(
      .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_FP(HFP),
      .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_FP(VFP),
      .HS_POL(1), .VS_POL(1), .CNT_W(CW), .CHK_LOG2(CHK)
   ) dut_p (
      .PixelClk(PixelClk), .RST(RST), .Mode(Mode), .ScrollEn(ScrollEn),
      .SolidRGB(SolidRGB), .LCD_DE(p_de), .LCD_HSYNC(p_hs), .LCD_VSYNC(p_vs),
      .LCD_R(p_r), .LCD_G(p_g), .LCD_B(p_b), .PixelX(p_px), .PixelY(p_py),
      .FrameStart(p_fs)
   );

   always #5 PixelClk = ~PixelClk;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // Reference model: position within the frame plus the frame-latched controls.
   int          m_pos = 0, m_off = 0, m_mode = 0;
   logic        m_scroll = 1'b0;
   logic [15:0] m_solid = 16'h0000;

   logic        e_de, e_hs, e_vs, e_fs;
   logic [15:0] e_rgb;
   int          e_px, e_py;

   function automatic logic [15:0] model_pixel(int mode, int xs, int y, logic [15:0] solid);
      int idx;
      case (mode)
         0: begin
            idx = xs / (HA / 8);
            if (idx > 7) idx = 7;
            case (idx)
               0:       return 16'hFFFF;
               1:       return 16'hFFE0;
               2:       return 16'h07FF;
               3:       return 16'h07E0;
               4:       return 16'hF81F;
               5:       return 16'hF800;
               6:       return 16'h001F;
               default: return 16'h0000;
            endcase
         end
         1:       return {5'((xs / 8) % 32), 6'((y / 4) % 64), 5'(((xs + y) % 256) / 8)};
         2:       return ((((xs / (2 ** CHK)) ^ (y / (2 ** CHK))) % 2) == 1) ? 16'hFFFF : 16'h0000;
         default: return solid;
      endcase
   endfunction

   function automatic logic [87:0] act_bundle();
      return {n_de, n_hs, n_vs, p_hs, p_vs, n_fs, n_rgb, n_px, n_py,
              p_de, p_fs, p_r, p_g, p_b, p_px, p_py};
   endfunction

   function automatic logic [87:0] exp_bundle();
      return {e_de, ~e_hs, ~e_vs, e_hs, e_vs, e_fs, e_rgb, CW'(e_px), CW'(e_py),
              e_de, e_fs, e_rgb, CW'(e_px), CW'(e_py)};
   endfunction

   // Predicts the outputs produced by the coming edge, then takes that edge.
   task automatic step_cycle(input logic rst);
      int h, v, x, y, xs;
      RST = rst;
      if (rst) begin
         e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0;
         e_rgb = 16'h0000; e_px = 0; e_py = 0;
         m_pos = 0; m_off = 0; m_mode = 0; m_scroll = 1'b0; m_solid = 16'h0000;
      end else begin
         h = m_pos % HT;
         v = m_pos / HT;
         x = h - (HS + HBP);
         y = v - (VS + VBP);
         e_hs  = (h < HS);
         e_vs  = (v < VS);
         e_fs  = (m_pos == 0);
         e_de  = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
         e_rgb = 16'h0000; e_px = 0; e_py = 0;
         if (e_de) begin
            xs    = (x + m_off) % HA;
            e_px  = x;
            e_py  = y;
            e_rgb = model_pixel(m_mode, xs, y, m_solid);
         end
         if (m_pos == 0) begin
            if (m_scroll) m_off = (m_off + 1) % HA;
            m_mode   = Mode;
            m_scroll = ScrollEn;
            m_solid  = SolidRGB;
         end
         m_pos = (m_pos + 1) % FT;
      end
      @(posedge PixelClk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      logic [87:0] a, e;
      for (int i = 0; i < 3; i++) begin
         step_cycle(1'b1);
         a = act_bundle(); e = exp_bundle(); vectors++;
         if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL reset cyc=%0d got=%h want=%h", cyc, a, e);
         end
      end
   endtask

   task automatic test_timing();
      logic [87:0] a, e;
      int fs_cnt = 0, hs_low = 0, vs_low = 0, hs_high_p = 0, de_cnt = 0, last_fs = -1;
      Mode = 2'd3; ScrollEn = 1'b0; SolidRGB = 16'($urandom);
      for (int c = 0; c < 2 * FT; c++) begin
         step_cycle(1'b0);
         a = act_bundle(); e = exp_bundle(); vectors++;
         if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL timing cyc=%0d got=%h want=%h", cyc, a, e);
         end
         if (n_fs === 1'b1) begin
            fs_cnt++;
            if (last_fs >= 0) begin
               vectors++;
               if (cyc - last_fs !== FT) begin
                  miscompares++;
                  $display("[TB] FAIL frame_period got=%0d want=%0d", cyc - last_fs, FT);
               end
            end
            last_fs = cyc;
         end
         if (n_hs === 1'b0) hs_low++;
         if (n_vs === 1'b0) vs_low++;
         if (p_hs === 1'b1) hs_high_p++;
         if (n_de === 1'b1) de_cnt++;
      end
      vectors += 5;
      if (fs_cnt !== 2) begin
         miscompares++; $display("[TB] FAIL fs_count got=%0d want=2", fs_cnt);
      end
      if (hs_low !== 2 * VT) begin
         miscompares++; $display("[TB] FAIL hsync_low got=%0d want=%0d", hs_low, 2 * VT);
      end
      if (hs_high_p !== 2 * VT) begin
         miscompares++; $display("[TB] FAIL hsync_pos_high got=%0d want=%0d", hs_high_p, 2 * VT);
      end
      if (vs_low !== 2 * HT) begin
         miscompares++; $display("[TB] FAIL vsync_low got=%0d want=%0d", vs_low, 2 * HT);
      end
      if (de_cnt !== 64) begin
         miscompares++; $display("[TB] FAIL de_count got=%0d want=64", de_cnt);
      end
   endtask

   task automatic test_solid();
      logic [87:0] a, e;
      Mode = 2'd3; SolidRGB = 16'hF800;
      for (int c = 0; c < FT; c++) begin
         step_cycle(1'b0);
         a = act_bundle(); e = exp_bundle(); vectors++;
         if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL solid cyc=%0d got=%h want=%h", cyc, a, e);
         end
         vectors++;
         if (n_rgb !== (n_de ? 16'hF800 : 16'h0000)) begin
            miscompares++;
            $display("[TB] FAIL solid_red cyc=%0d got=%h de=%b", cyc, n_rgb, n_de);
         end
      end
   endtask

   task automatic test_mode_switch();
      logic [87:0] a, e;
      logic [15:0] solid, line0 [4];
      solid = 16'($urandom);
      Mode = 2'd3; ScrollEn = 1'b0; SolidRGB = solid;
      for (int c = 0; c < 2 * FT; c++) begin
         if (c == 40) Mode = 2'd2;
         step_cycle(1'b0);
         a = act_bundle(); e = exp_bundle(); vectors++;
         if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL mode_switch cyc=%0d got=%h want=%h", cyc, a, e);
         end
         if (c < FT && n_de === 1'b1) begin
            vectors++;
            if (n_rgb !== solid) begin
               miscompares++;
               $display("[TB] FAIL no_tear cyc=%0d got=%h want=%h", cyc, n_rgb, solid);
            end
         end
         if (c >= FT && n_de === 1'b1 && n_py == 0 && n_px < 4) line0[n_px[1:0]] = n_rgb;
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (line0[i] !== ((i >= 2) ? 16'hFFFF : 16'h0000)) begin
            miscompares++;
            $display("[TB] FAIL checker x=%0d got=%h want=%h", i, line0[i],
                     (i >= 2) ? 16'hFFFF : 16'h0000);
         end
      end
   endtask

   task automatic test_bars();
      logic [87:0] a, e;
      logic [15:0] seq [11][8];
      Mode = 2'd0; ScrollEn = 1'b0;
      for (int f = 0; f < 11; f++) begin
         if (f == 1) ScrollEn = 1'b1;
         for (int c = 0; c < FT; c++) begin
            step_cycle(1'b0);
            a = act_bundle(); e = exp_bundle(); vectors++;
            if (a !== e) begin
               miscompares++;
               $display("[TB] FAIL bars cyc=%0d got=%h want=%h", cyc, a, e);
            end
            if (n_de === 1'b1 && n_py == 0) seq[f][n_px[2:0]] = n_rgb;
         end
      end
      // Frame f (f>=1) is rotated left by f-1; frame 9 wraps back to frame 0.
      for (int i = 0; i < 8; i++) begin
         vectors += 4;
         if (seq[0][i] !== model_pixel(0, i, 0, 16'h0000)) begin
            miscompares++;
            $display("[TB] FAIL bar_order x=%0d got=%h want=%h", i, seq[0][i], model_pixel(0, i, 0, 16'h0000));
         end
         if (seq[2][i] !== seq[0][(i + 1) % 8]) begin
            miscompares++;
            $display("[TB] FAIL scroll_1 x=%0d got=%h want=%h", i, seq[2][i], seq[0][(i + 1) % 8]);
         end
         if (seq[5][i] !== seq[0][(i + 4) % 8]) begin
            miscompares++;
            $display("[TB] FAIL scroll_4 x=%0d got=%h want=%h", i, seq[5][i], seq[0][(i + 4) % 8]);
         end
         if (seq[9][i] !== seq[0][i]) begin
            miscompares++;
            $display("[TB] FAIL scroll_wrap x=%0d got=%h want=%h", i, seq[9][i], seq[0][i]);
         end
      end
   endtask

   task automatic test_random();
      logic [87:0] a, e;
      for (int c = 0; c < 6 * FT; c++) begin
         if ($urandom_range(19) == 0) begin
            Mode     = 2'($urandom_range(3));
            ScrollEn = 1'($urandom_range(1));
            SolidRGB = 16'($urandom);
         end
         step_cycle(1'b0);
         a = act_bundle(); e = exp_bundle(); vectors++;
         if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL random cyc=%0d got=%h want=%h", cyc, a, e);
         end
      end
   endtask

   task automatic test_mid_reset();
      logic [87:0] a, e;
      int fs_cnt = 0, hs_low = 0, vs_low = 0, de_cnt = 0;
      for (int i = 0; i < FT && m_pos != 3 * HT + 7; i++) begin
         step_cycle(1'b0);
         a = act_bundle(); e = exp_bundle(); vectors++;
         if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL pre_reset cyc=%0d got=%h want=%h", cyc, a, e);
         end
      end
      step_cycle(1'b1);
      vectors++;
      if (n_de !== 1'b0) begin
         miscompares++; $display("[TB] FAIL mid_reset_de got=%b want=0", n_de);
      end
      for (int c = 0; c < FT; c++) begin
         step_cycle(1'b0);
         a = act_bundle(); e = exp_bundle(); vectors++;
         if (a !== e) begin
            miscompares++;
            $display("[TB] FAIL post_reset cyc=%0d got=%h want=%h", cyc, a, e);
         end
         if (c == 0) begin
            vectors++;
            if (n_fs !== 1'b1) begin
               miscompares++; $display("[TB] FAIL restart_fs got=%b want=1", n_fs);
            end
         end
         if (n_fs === 1'b1) fs_cnt++;
         if (n_hs === 1'b0) hs_low++;
         if (n_vs === 1'b0) vs_low++;
         if (n_de === 1'b1) de_cnt++;
      end
      vectors++;
      if (fs_cnt !== 1 || hs_low !== VT || vs_low !== HT || de_cnt !== 32) begin
         miscompares++;
         $display("[TB] FAIL restart_frame got fs=%0d hs=%0d vs=%0d de=%0d want 1/%0d/%0d/32",
                  fs_cnt, hs_low, vs_low, de_cnt, VT, HT);
      end
   endtask

   initial begin
      test_reset();
      test_timing();
      test_solid();
      test_mode_switch();
      test_bars();
      test_random();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
